// File: rtl/systolic_stream_if.sv
// Operand and result streams of the systolic_stream engine.
// The engine uses the slave modport; the producer/consumer side uses master.
interface systolic_stream_if #(
    parameter int D_W     = 8,
    parameter int D_W_ACC = 16,
    parameter int ROWS    = 3,
    parameter int COLS    = 3
);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    logic                      in_valid;
    logic                      in_ready;
    logic [ROWS*D_W-1:0]       a_in;
    logic [COLS*D_W-1:0]       b_in;
    logic                      out_valid;
    logic                      out_ready;
    logic [COLS*D_W_ACC-1:0]   out_data;
    logic [ROW_W-1:0]          out_row;
    logic                      out_last;

    modport master (
        output in_valid, a_in, b_in, out_ready,
        input  in_ready, out_valid, out_data, out_row, out_last
    );

    modport slave (
        input  in_valid, a_in, b_in, out_ready,
        output in_ready, out_valid, out_data, out_row, out_last
    );
endinterface

// File: rtl/systolic_stream.sv
// Output-stationary ROWS x COLS systolic matrix multiply, D = A*B.
// One operand beat per k (column of A, row of B), internal skewing, then a
// flush of ROWS+COLS-1 zero steps and a back-pressured drain, one row per
// handshake. Optional macro SYSTOLIC_SIGNED_EN selects two's complement
// operands with sign-extended products; otherwise arithmetic is unsigned.
module systolic_stream #(
    parameter int D_W     = 8,
    parameter int D_W_ACC = 16,
    parameter int ROWS    = 3,
    parameter int COLS    = 3,
    parameter int K_MAX   = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    input  logic [$clog2(K_MAX+1)-1:0]   i_k_len,
    systolic_stream_if.slave             s_if,
    output logic                         o_busy,
    output logic                         o_done
);
    localparam int K_W   = $clog2(K_MAX + 1);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FL_N  = ROWS + COLS - 1;
    localparam int FL_W  = $clog2(FL_N + 1);
    localparam int PW    = D_W_ACC + 2 * D_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    // Full-width product, extended (or truncated) to the accumulator width.
    function automatic logic [D_W_ACC-1:0] mul_ext(input logic [D_W-1:0] a,
                                                   input logic [D_W-1:0] b);
        logic [2*D_W-1:0] sa;
        logic [2*D_W-1:0] sb;
        logic [2*D_W-1:0] p;
        logic [PW-1:0]    wide;
`ifdef SYSTOLIC_SIGNED_EN
        sa   = {{D_W{a[D_W-1]}}, a};
        sb   = {{D_W{b[D_W-1]}}, b};
        p    = sa * sb;
        wide = {{D_W_ACC{p[2*D_W-1]}}, p};
`else
        sa   = {{D_W{1'b0}}, a};
        sb   = {{D_W{1'b0}}, b};
        p    = sa * sb;
        wide = {{D_W_ACC{1'b0}}, p};
`endif
        return wide[D_W_ACC-1:0];
    endfunction

    state_t             r_state;
    state_t             w_state_nxt;
    logic [K_W-1:0]     r_k_len;
    logic [K_W-1:0]     r_beat_cnt;
    logic [K_W-1:0]     w_k_clamp;
    logic [FL_W-1:0]    r_flush_cnt;
    logic               w_clear;
    logic               w_step;
    logic               w_accept;
    logic               w_hs;
    logic               w_done_nxt;
    logic [ROW_W-1:0]   w_row_nxt;

    logic                      r_in_ready;
    logic                      r_out_valid;
    logic [COLS*D_W_ACC-1:0]   r_out_data;
    logic [ROW_W-1:0]          r_out_row;
    logic                      r_out_last;
    logic                      r_busy;
    logic                      r_done;
    logic [COLS*D_W_ACC-1:0]   w_row_data;

    logic [D_W-1:0]     w_a_op   [ROWS];
    logic [D_W-1:0]     w_b_op   [COLS];
    logic [D_W-1:0]     w_a_edge [ROWS];
    logic [D_W-1:0]     w_b_edge [COLS];

    logic [D_W-1:0]     r_a_pe     [ROWS][COLS];
    logic [D_W-1:0]     r_b_pe     [ROWS][COLS];
    logic [D_W-1:0]     w_a_pe_in  [ROWS][COLS];
    logic [D_W-1:0]     w_b_pe_in  [ROWS][COLS];
    logic [D_W_ACC-1:0] r_acc      [ROWS][COLS];
    logic [D_W_ACC-1:0] w_acc_nxt  [ROWS][COLS];

    assign w_accept = r_in_ready && s_if.in_valid;
    assign w_hs     = r_out_valid && s_if.out_ready;

    // Clamp the requested inner length to the supported maximum.
    always_comb begin
        if (i_k_len > K_W'(K_MAX)) begin
            w_k_clamp = K_W'(K_MAX);
        end else begin
            w_k_clamp = i_k_len;
        end
    end

    // Next-state and step/clear control for the job sequencer.
    always_comb begin
        w_state_nxt = r_state;
        w_clear     = 1'b0;
        w_step      = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_clear = 1'b1;
                    if (w_k_clamp == '0) begin
                        w_state_nxt = ST_DRAIN;
                    end else begin
                        w_state_nxt = ST_LOAD;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (w_accept) begin
                    w_step = 1'b1;
                    if (r_beat_cnt == (r_k_len - K_W'(1))) begin
                        w_state_nxt = ST_FLUSH;
                    end else begin
                        w_state_nxt = ST_LOAD;
                    end
                end else begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_FLUSH: begin
                w_step = 1'b1;
                if (r_flush_cnt == FL_W'(FL_N - 1)) begin
                    w_state_nxt = ST_DRAIN;
                end else begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_DRAIN: begin
                if (w_hs && r_out_last) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register plus job length, beat and flush counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_k_len     <= '0;
            r_beat_cnt  <= '0;
            r_flush_cnt <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_clear) begin
                r_k_len     <= w_k_clamp;
                r_beat_cnt  <= '0;
                r_flush_cnt <= '0;
            end else begin
                if (w_accept && (r_state == ST_LOAD)) begin
                    r_beat_cnt <= r_beat_cnt + K_W'(1);
                end
                if (r_state == ST_FLUSH) begin
                    r_flush_cnt <= r_flush_cnt + FL_W'(1);
                end
            end
        end
    end

    // Operands entering the skew lines: the beat when accepted, zero while flushing.
    always_comb begin
        for (int i = 0; i < ROWS; i++) begin
            if (w_accept && (r_state == ST_LOAD)) begin
                w_a_op[i] = s_if.a_in[i*D_W +: D_W];
            end else begin
                w_a_op[i] = '0;
            end
        end
        for (int j = 0; j < COLS; j++) begin
            if (w_accept && (r_state == ST_LOAD)) begin
                w_b_op[j] = s_if.b_in[j*D_W +: D_W];
            end else begin
                w_b_op[j] = '0;
            end
        end
    end

    // Row i of A is delayed i steps before entering the array.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_askew
        if (gi == 0) begin : g_direct
            assign w_a_edge[gi] = w_a_op[gi];
        end else begin : g_delay
            logic [D_W-1:0] r_sk [gi];
            // Delay line that advances only when the array steps.
            always_ff @(posedge clk) begin
                if (rst || w_clear) begin
                    for (int n = 0; n < gi; n++) r_sk[n] <= '0;
                end else if (w_step) begin
                    r_sk[0] <= w_a_op[gi];
                    for (int n = 1; n < gi; n++) r_sk[n] <= r_sk[n-1];
                end
            end
            assign w_a_edge[gi] = r_sk[gi-1];
        end
    end

    // Column j of B is delayed j steps before entering the array.
    for (genvar gj = 0; gj < COLS; gj++) begin : g_bskew
        if (gj == 0) begin : g_direct
            assign w_b_edge[gj] = w_b_op[gj];
        end else begin : g_delay
            logic [D_W-1:0] r_sk [gj];
            // Delay line that advances only when the array steps.
            always_ff @(posedge clk) begin
                if (rst || w_clear) begin
                    for (int n = 0; n < gj; n++) r_sk[n] <= '0;
                end else if (w_step) begin
                    r_sk[0] <= w_b_op[gj];
                    for (int n = 1; n < gj; n++) r_sk[n] <= r_sk[n-1];
                end
            end
            assign w_b_edge[gj] = r_sk[gj-1];
        end
    end

    // PE wiring: a flows right, b flows down; accumulator next value.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
        for (genvar gj = 0; gj < COLS; gj++) begin : g_col
            if (gj == 0) begin : g_a_edge
                assign w_a_pe_in[gi][gj] = w_a_edge[gi];
            end else begin : g_a_pass
                assign w_a_pe_in[gi][gj] = r_a_pe[gi][gj-1];
            end
            if (gi == 0) begin : g_b_edge
                assign w_b_pe_in[gi][gj] = w_b_edge[gj];
            end else begin : g_b_pass
                assign w_b_pe_in[gi][gj] = r_b_pe[gi-1][gj];
            end
            assign w_acc_nxt[gi][gj] = w_clear ? '0 :
                (w_step ? (r_acc[gi][gj] + mul_ext(w_a_pe_in[gi][gj], w_b_pe_in[gi][gj]))
                        : r_acc[gi][gj]);
        end
    end

    // PE operand pipeline and accumulators.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    r_a_pe[i][j] <= '0;
                    r_b_pe[i][j] <= '0;
                    r_acc[i][j]  <= '0;
                end
            end
        end else begin
            for (int i = 0; i < ROWS; i++) begin
                for (int j = 0; j < COLS; j++) begin
                    r_acc[i][j] <= w_acc_nxt[i][j];
                    if (w_clear) begin
                        r_a_pe[i][j] <= '0;
                        r_b_pe[i][j] <= '0;
                    end else if (w_step) begin
                        r_a_pe[i][j] <= w_a_pe_in[i][j];
                        r_b_pe[i][j] <= w_b_pe_in[i][j];
                    end
                end
            end
        end
    end

    // Row to present next; advances only on a drain handshake.
    always_comb begin
        if (r_state == ST_DRAIN) begin
            if (w_hs && !r_out_last) begin
                w_row_nxt = r_out_row + ROW_W'(1);
            end else begin
                w_row_nxt = r_out_row;
            end
        end else begin
            w_row_nxt = '0;
        end
    end

    // Gather the selected row of final accumulator values.
    always_comb begin
        w_row_data = '0;
        for (int j = 0; j < COLS; j++) begin
            w_row_data[j*D_W_ACC +: D_W_ACC] = w_acc_nxt[w_row_nxt][j];
        end
    end

    // Registered status and result outputs, derived from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_row   <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_in_ready  <= (w_state_nxt == ST_LOAD);
            r_out_valid <= (w_state_nxt == ST_DRAIN);
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_done      <= w_done_nxt;
            if (w_state_nxt == ST_DRAIN) begin
                r_out_row  <= w_row_nxt;
                r_out_data <= w_row_data;
                r_out_last <= (w_row_nxt == ROW_W'(ROWS - 1));
            end else begin
                r_out_row  <= '0;
                r_out_data <= '0;
                r_out_last <= 1'b0;
            end
        end
    end

    assign s_if.in_ready  = r_in_ready;
    assign s_if.out_valid = r_out_valid;
    assign s_if.out_data  = r_out_data;
    assign s_if.out_row   = r_out_row;
    assign s_if.out_last  = r_out_last;
    assign o_busy         = r_busy;
    assign o_done         = r_done;
endmodule

// File: tb/tb_systolic_stream.sv
// Self-checking bench for systolic_stream: directed jobs from the test plan
// plus randomized jobs, all compared against a plain matrix-product model.
module tb_systolic_stream;
    localparam int D_W = 8;
    localparam int ACC = 16;
    localparam int R   = 3;
    localparam int C   = 3;
    localparam int KM  = 16;

    logic       clk;
    logic       rst;
    logic       start;
    logic [4:0] k_len;
    logic       busy;
    logic       done;

    int n_total;
    int n_bad;
    int ma [R][KM];
    int mb [KM][C];
    logic [C*ACC-1:0] obs [R];

    systolic_stream_if #(.D_W(D_W), .D_W_ACC(ACC), .ROWS(R), .COLS(C)) bus ();

    systolic_stream #(.D_W(D_W), .D_W_ACC(ACC), .ROWS(R), .COLS(C), .K_MAX(KM)) u_dut (
        .clk     (clk),
        .rst     (rst),
        .i_start (start),
        .i_k_len (k_len),
        .s_if    (bus),
        .o_busy  (busy),
        .o_done  (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int sx(input int x);
`ifdef SYSTOLIC_SIGNED_EN
        return (x > 127) ? (x - 256) : x;
`else
        return x;
`endif
    endfunction

    // Reference: D[i][j] = sum_k A[i][k]*B[k][j], modulo 2^ACC.
    function automatic logic [C*ACC-1:0] exp_row(input int i, input int keff);
        logic [C*ACC-1:0] r;
        int s;
        r = '0;
        for (int j = 0; j < C; j++) begin
            s = 0;
            for (int kk = 0; kk < keff; kk++) s += sx(ma[i][kk]) * sx(mb[kk][j]);
            r[j*ACC +: ACC] = s[ACC-1:0];
        end
        return r;
    endfunction

    task automatic fill_rand();
        for (int i = 0; i < R; i++) for (int kk = 0; kk < KM; kk++) ma[i][kk] = $urandom_range(0, 255);
        for (int kk = 0; kk < KM; kk++) for (int j = 0; j < C; j++) mb[kk][j] = $urandom_range(0, 255);
    endtask

    task automatic drive_beat(input int idx);
        logic [R*D_W-1:0] av;
        logic [C*D_W-1:0] bv;
        int ai;
        int bi;
        av = '0;
        bv = '0;
        for (int i = 0; i < R; i++) begin
            ai = ma[i][idx];
            av[i*D_W +: D_W] = ai[D_W-1:0];
        end
        for (int j = 0; j < C; j++) begin
            bi = mb[idx][j];
            bv[j*D_W +: D_W] = bi[D_W-1:0];
        end
        bus.a_in = av;
        bus.b_in = bv;
    endtask

    // bmode: 0 none, 1 alternate, 2 random bubbles. smode: 0 ready, 1 stall row 1 x4, 2 random.
    task automatic run_job(input int k, input int bmode, input int smode);
        int keff, t, idx, row, bubbles, stalls, first_t, stall_left;
        bit v, rdy, hs, ordy, fin, alt;
        keff = (k > KM) ? KM : k;
        start = 1'b1;
        k_len = 5'(k);
        @(posedge clk); #1;
        start = 1'b0;
        t = 1;
        check_val("busy_rise", 64'(busy), 64'(1));
        check_val("in_ready_rise", 64'(bus.in_ready), 64'(keff > 0));
        idx = 0; row = 0; bubbles = 0; stalls = 0; first_t = -1;
        stall_left = 4; fin = 1'b0; alt = 1'b0;
        while (!fin && t < 400) begin
            rdy = bus.in_ready;
            if (keff == 0) begin
                check_val("no_beat_k0", 64'(rdy), 64'(0));
                v = 1'b1;
                drive_beat($urandom_range(0, KM - 1));
            end else if (idx < keff && rdy) begin
                if (bmode == 1) begin
                    v = alt;
                    alt = !alt;
                end else if (bmode == 2) begin
                    v = ($urandom_range(0, 2) != 0);
                end else begin
                    v = 1'b1;
                end
                drive_beat(idx);
            end else begin
                v = 1'b0;
            end
            bus.in_valid = v;
            if (rdy && !v) bubbles++;
            hs = 1'b0;
            ordy = 1'b1;
            if (bus.out_valid) begin
                if (first_t < 0) first_t = t;
                check_val("out_row", 64'(bus.out_row), 64'(row));
                check_val("out_data", 64'(bus.out_data), 64'(exp_row(row, keff)));
                check_val("out_last", 64'(bus.out_last), 64'(row == R - 1));
                if (smode == 1) begin
                    if (row == 1 && stall_left > 0) begin
                        ordy = 1'b0;
                        stall_left--;
                    end
                end else if (smode == 2) begin
                    ordy = ($urandom_range(0, 1) == 1);
                end
                if (!ordy) stalls++;
                hs = ordy;
                if (hs) obs[row] = bus.out_data;
            end
            bus.out_ready = ordy;
            @(posedge clk); #1;
            t++;
            if (rdy && v && keff > 0) idx++;
            if (hs) begin
                if (row == R - 1) fin = 1'b1;
                else row++;
            end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        if (!fin) check_val("timeout", 64'(0), 64'(1));
        check_val("beats_taken", 64'(idx), 64'(keff));
        check_val("first_valid_t", 64'(first_t), 64'((keff == 0) ? 1 : keff + R + C + bubbles));
        check_val("done_t", 64'(t), 64'(((keff == 0) ? 1 : keff + R + C + bubbles) + R + stalls));
        check_val("done_pulse", 64'(done), 64'(1));
        check_val("busy_fall", 64'(busy), 64'(0));
        @(posedge clk); #1;
        check_val("done_clear", 64'(done), 64'(0));
    endtask

    task automatic check_reset_outputs();
        check_val("rst_in_ready", 64'(bus.in_ready), 64'(0));
        check_val("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check_val("rst_out_data", 64'(bus.out_data), 64'(0));
        check_val("rst_out_row", 64'(bus.out_row), 64'(0));
        check_val("rst_out_last", 64'(bus.out_last), 64'(0));
        check_val("rst_busy", 64'(busy), 64'(0));
        check_val("rst_done", 64'(done), 64'(0));
    endtask

    task automatic set_identity_job();
        for (int i = 0; i < R; i++) for (int kk = 0; kk < KM; kk++) ma[i][kk] = (i == kk) ? 1 : 0;
        for (int kk = 0; kk < KM; kk++) for (int j = 0; j < C; j++) mb[kk][j] = (kk < 3) ? (kk * 3 + j + 1) : 0;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        rst = 1'b1;
        start = 1'b0;
        k_len = '0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a_in = '0;
        bus.b_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst = 1'b0;
        @(posedge clk); #1;

        // Identity A times B: rows reproduce B; plain, bubbled, stalled drain.
        set_identity_job();
        run_job(3, 0, 0);
        for (int i = 0; i < R; i++)
            check_val("ident_row_direct", 64'(obs[i]),
                      64'({16'(i * 3 + 3), 16'(i * 3 + 2), 16'(i * 3 + 1)}));
        run_job(3, 1, 0);
        run_job(3, 0, 1);

        // All operands 255, k=3.
        for (int i = 0; i < R; i++) for (int kk = 0; kk < KM; kk++) ma[i][kk] = 255;
        for (int kk = 0; kk < KM; kk++) for (int j = 0; j < C; j++) mb[kk][j] = 255;
        run_job(3, 0, 0);
`ifdef SYSTOLIC_SIGNED_EN
        check_val("all255_entry", 64'(obs[2][ACC-1:0]), 64'(3));
`else
        check_val("all255_entry", 64'(obs[2][ACC-1:0]), 64'(64003));
`endif

        // Zero inner length with in_valid held high.
        fill_rand();
        run_job(0, 0, 0);

        // Reset in the middle of LOAD after two beats.
        fill_rand();
        start = 1'b1;
        k_len = 5'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int b = 0; b < 2; b++) begin
            drive_beat(b);
            bus.in_valid = 1'b1;
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        fill_rand();
        run_job(3, 0, 0);

        // Randomized jobs, including a length above K_MAX.
        for (int n = 0; n < 8; n++) begin
            fill_rand();
            run_job((n == 5) ? 20 : $urandom_range(1, KM), 2, 2);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
